// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer on refclk: pulses the PLL reset, waits for lock with
// timeout/retry, qualifies lock stability, then releases the system reset.
module pll_lock_sequencer #(
  parameter int PLL_RST_CYCLES = 24,
  parameter int LOCK_TIMEOUT   = 24000,
  parameter int LOCK_STABLE    = 240
) (
  input  logic       refclk,
  input  logic       reset_n,
  input  logic       extlock,
  input  logic       restart,
  output logic       pll_reset,
  output logic       sys_reset_n,
  output logic       ready,
  output logic       lock_lost,
  output logic [3:0] retry_count
);

  localparam int MAXP = (PLL_RST_CYCLES > LOCK_TIMEOUT)
                      ? ((PLL_RST_CYCLES > LOCK_STABLE) ? PLL_RST_CYCLES : LOCK_STABLE)
                      : ((LOCK_TIMEOUT > LOCK_STABLE) ? LOCK_TIMEOUT : LOCK_STABLE);
  localparam int CW = $clog2(MAXP + 1);

  localparam logic [CW-1:0] C_RST_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] C_TO_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] C_LS_LAST  = CW'(LOCK_STABLE - 1);

  if (PLL_RST_CYCLES < 1 || LOCK_TIMEOUT < 1 || LOCK_STABLE < 1) begin : g_param_check
    $error("pll_lock_sequencer: all cycle parameters must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_RST_PLL   = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [3:0]      r_retry, w_retry_nxt;
  logic            w_lost_nxt;
  logic            r_lock_meta, r_lock_s;
  logic            r_pll_reset, r_sys_reset_n, r_ready, r_lock_lost;

  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_lock_meta <= extlock;
      r_lock_s    <= r_lock_meta;
    end
  end

  // Counter holds "edges already spent in state", so each exit compares against N-1.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_retry_nxt = r_retry;
    w_lost_nxt  = 1'b0;
    case (r_state)
      ST_RST_PLL: begin
        if (r_cnt == C_RST_LAST) w_state_nxt = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (r_lock_s) begin
          w_state_nxt = ST_STABLE;
        end else if (r_cnt == C_TO_LAST) begin
          w_state_nxt = ST_RST_PLL;
          if (r_retry != 4'hF) w_retry_nxt = r_retry + 4'd1;
        end
      end
      ST_STABLE: begin
        if (!r_lock_s)                w_state_nxt = ST_WAIT_LOCK;
        else if (r_cnt == C_LS_LAST)  w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        w_cnt_nxt = '0;
        if (!r_lock_s) begin
          w_state_nxt = ST_RST_PLL;
          w_lost_nxt  = 1'b1;
        end else if (restart) begin
          w_state_nxt = ST_RST_PLL;
        end
      end
      default: w_state_nxt = ST_RST_PLL;
    endcase
    if (w_state_nxt != r_state) w_cnt_nxt = '0;
  end

  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_RST_PLL;
      r_cnt         <= '0;
      r_retry       <= '0;
      r_pll_reset   <= 1'b1;
      r_sys_reset_n <= 1'b0;
      r_ready       <= 1'b0;
      r_lock_lost   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_retry       <= w_retry_nxt;
      r_pll_reset   <= (w_state_nxt == ST_RST_PLL);
      r_sys_reset_n <= (w_state_nxt == ST_RUN);
      r_ready       <= (w_state_nxt == ST_RUN);
      r_lock_lost   <= w_lost_nxt;
    end
  end

  assign pll_reset   = r_pll_reset;
  assign sys_reset_n = r_sys_reset_n;
  assign ready       = r_ready;
  assign lock_lost   = r_lock_lost;
  assign retry_count = r_retry;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Randomized bench for pll_lock_sequencer: per-edge behavioural model with
// elapsed-time arithmetic, plus hand-computed edge-number expectations.
module tb_pll_lock_sequencer;

  localparam int P_RST = 4;
  localparam int P_TO  = 20;
  localparam int P_LS  = 8;

  localparam int PH_RST  = 0;
  localparam int PH_WAIT = 1;
  localparam int PH_STB  = 2;
  localparam int PH_RUN  = 3;

  logic       refclk = 1'b0;
  logic       reset_n;
  logic       extlock;
  logic       restart;
  logic       pll_reset;
  logic       sys_reset_n;
  logic       ready;
  logic       lock_lost;
  logic [3:0] retry_count;

  int n_chk  = 0;
  int n_pass = 0;

  pll_lock_sequencer #(
    .PLL_RST_CYCLES(P_RST),
    .LOCK_TIMEOUT  (P_TO),
    .LOCK_STABLE   (P_LS)
  ) dut (
    .refclk     (refclk),
    .reset_n    (reset_n),
    .extlock    (extlock),
    .restart    (restart),
    .pll_reset  (pll_reset),
    .sys_reset_n(sys_reset_n),
    .ready      (ready),
    .lock_lost  (lock_lost),
    .retry_count(retry_count)
  );

  always #5 refclk = ~refclk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Model: phase, edge of phase entry, and a short history of sampled extlock.
  int m_n, m_ent, m_ph, m_retry;
  bit m_lost;
  bit hist[$];

  task automatic model_reset();
    m_n = 0; m_ent = 0; m_ph = PH_RST; m_retry = 0; m_lost = 0;
    hist.delete();
  endtask

  task automatic enter(input int ph);
    m_ph  = ph;
    m_ent = m_n;
  endtask

  task automatic model_step();
    bit ls;
    int el;
    m_n++;
    ls = (hist.size() >= 2) ? hist[hist.size()-2] : 1'b0;
    hist.push_back(extlock);
    if (hist.size() > 4) void'(hist.pop_front());
    el = m_n - m_ent;
    m_lost = 0;
    case (m_ph)
      PH_RST:  if (el == P_RST) enter(PH_WAIT);
      PH_WAIT: if (ls) enter(PH_STB);
               else if (el == P_TO) begin
                 enter(PH_RST);
                 if (m_retry < 15) m_retry++;
               end
      PH_STB:  if (!ls) enter(PH_WAIT);
               else if (el == P_LS) enter(PH_RUN);
      default: if (!ls) begin m_lost = 1; enter(PH_RST); end
               else if (restart) enter(PH_RST);
    endcase
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge refclk or negedge reset_n);
      if (!reset_n) model_reset();
      else          model_step();
      #1;
      chk("outputs_vs_model",
          {24'd0, pll_reset, sys_reset_n, ready, lock_lost, retry_count},
          {24'd0, m_ph == PH_RST, m_ph == PH_RUN, m_ph == PH_RUN, m_lost, 4'(m_retry)});
    end
  end

  int e;

  task automatic step();
    @(posedge refclk);
    #2;
    e++;
  endtask

  task automatic to(input int k);
    while (e < k) step();
  endtask

  task automatic wait_run(input string nm);
    int i;
    for (i = 0; i < 300 && m_ph != PH_RUN; i++) step();
    if (m_ph != PH_RUN) chk({nm, "_timeout"}, m_ph, PH_RUN);
  endtask

  initial begin
    int hold;
    extlock = 1'b1;
    restart = 1'b0;
    reset_n = 1'b0;
    e = 0;
    repeat (3) step();
    reset_n = 1'b1;
    e = 0;

    // Power-up with lock already present
    to(3);  chk("pu_pll_reset_e3", pll_reset, 1);
    to(4);  chk("pu_pll_reset_e4", pll_reset, 0);
    to(12); chk("pu_sys_e12", sys_reset_n, 0);
    to(13); chk("pu_sys_e13", sys_reset_n, 1);
            chk("pu_ready_e13", ready, 1);
            chk("pu_retry", retry_count, 0);

    // Restart alone in RUN, then a one-cycle lock glitch mid-STABLE
    to(20); restart = 1'b1;
    to(21); restart = 1'b0;
            chk("rs_pll_reset", pll_reset, 1);
            chk("rs_no_lost", lock_lost, 0);
            chk("rs_ready", ready, 0);
    to(29); extlock = 1'b0;
    to(30); extlock = 1'b1;
    to(32); chk("gl_sys_stays0", sys_reset_n, 0);
    to(34); chk("gl_no_early_run", ready, 0);
    to(40); chk("gl_ready_e40", ready, 0);
    to(41); chk("gl_ready_e41", ready, 1);
            chk("gl_retry", retry_count, 0);

    // Loss of lock in RUN, then repeated timeouts to saturation
    to(50); extlock = 1'b0;
    to(52); chk("ll_ready_e52", ready, 1);
    to(53); chk("ll_lost_e53", lock_lost, 1);
            chk("ll_sys_e53", sys_reset_n, 0);
            chk("ll_pll_e53", pll_reset, 1);
    to(54); chk("ll_lost_e54", lock_lost, 0);
    to(76); chk("to_retry_e76", retry_count, 0);
    to(77); chk("to_retry_e77", retry_count, 1);
            chk("to_pll_e77", pll_reset, 1);
    to(80); chk("to_pll_e80", pll_reset, 1);
    to(81); chk("to_pll_e81", pll_reset, 0);
    to(412); chk("sat_retry14", retry_count, 14);
    to(413); chk("sat_retry15", retry_count, 15);
    to(461); chk("sat_hold15", retry_count, 15);

    // restart while waiting for lock is ignored (model checks every edge)
    restart = 1'b1;
    repeat (12) step();
    restart = 1'b0;

    // Lock loss and restart in the same cycle: the pulse still appears
    extlock = 1'b1;
    wait_run("sim_run");
    repeat (3) step();
    extlock = 1'b0;
    step(); step();
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("sim_lost", lock_lost, 1);

    // restart alone from RUN
    extlock = 1'b1;
    wait_run("rs2_run");
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("rs2_pll", pll_reset, 1);
    chk("rs2_no_lost", lock_lost, 0);

    // Randomized extlock hold times and restart requests
    for (int i = 0; i < 3000; ) begin
      hold = $urandom_range(1, 40);
      extlock = ($urandom_range(0, 3) != 0);
      for (int j = 0; j < hold; j++) begin
        restart = ($urandom_range(0, 15) == 0);
        step();
        i++;
      end
    end
    restart = 1'b0;

    // Asynchronous reset while in RUN
    extlock = 1'b1;
    wait_run("ar_run");
    @(posedge refclk);
    #3 reset_n = 1'b0;
    #1;
    chk("ar_pll", pll_reset, 1);
    chk("ar_sys", sys_reset_n, 0);
    chk("ar_ready", ready, 0);
    chk("ar_lost", lock_lost, 0);
    chk("ar_retry", retry_count, 0);
    step();
    reset_n = 1'b1;
    e = 0;
    to(3);  chk("ar2_pll_e3", pll_reset, 1);
    to(4);  chk("ar2_pll_e4", pll_reset, 0);
    to(12); chk("ar2_ready_e12", ready, 0);
    to(13); chk("ar2_ready_e13", ready, 1);
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
